// File: rtl/voice_scheduler_if.sv
// Shared sample-BRAM read port and mixed-sample output of the voice scheduler.
interface voice_scheduler_if #(
  parameter int NOTE_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 13,
  parameter int SAMPLE_WIDTH = 16,
  parameter int MIX_WIDTH    = 18
);
  logic [NOTE_WIDTH+ADDR_WIDTH-1:0] rd_addr_out;
  logic [SAMPLE_WIDTH-1:0]          rd_data_in;
  logic [MIX_WIDTH-1:0]             mix_out;
  logic                             mix_valid_out;

  modport master (output rd_addr_out, mix_out, mix_valid_out, input rd_data_in);
  modport slave  (input rd_addr_out, mix_out, mix_valid_out, output rd_data_in);
endinterface

// File: rtl/voice_scheduler.sv
// Polyphonic voice allocator, shared-BRAM read scheduler and mixer, one frame per sample_tick.
// Define VOICE_STEAL_EN to let a press with all voices busy steal a voice round-robin.
//
// state  | meaning
// S_IDLE | waiting for sample_tick
// S_SCAN | one key per cycle: allocate on press, free on release
// S_READ | one voice per cycle drives the BRAM address
// S_WAIT | drain the BRAM latency into the accumulator
// S_DONE | mix_out holds the frame sum, mix_valid_out pulses
module voice_scheduler #(
  parameter int NUM_KEYS     = 12,
  parameter int NUM_VOICES   = 4,
  parameter int NOTE_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 13,
  parameter int SAMPLE_WIDTH = 16,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [NUM_KEYS-1:0]   touch_status_in,
  input  logic                  sample_tick,
  voice_scheduler_if.master     bus,
  output logic [NUM_VOICES-1:0] voice_active_out,
  output logic                  busy_out
);
  localparam int MIX_W = SAMPLE_WIDTH + $clog2(NUM_VOICES);
  localparam int CW    = $clog2(NUM_KEYS + NUM_VOICES + BRAM_LATENCY);
  localparam int KIW   = $clog2(NUM_KEYS);
  localparam int VIW   = $clog2(NUM_VOICES);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_READ, S_WAIT, S_DONE} state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [NUM_KEYS-1:0]     snap, prev;
  logic [NUM_VOICES-1:0]   active;
  logic [NOTE_WIDTH-1:0]   note  [NUM_VOICES];
  logic [ADDR_WIDTH-1:0]   phase [NUM_VOICES];
  logic [BRAM_LATENCY-1:0] tag;
  logic [MIX_W-1:0]        acc, acc_nx, mix;
  logic [KIW-1:0]          key_idx;
  logic [VIW-1:0]          rv, free_idx;
  logic                    free_found, read_hit, key_rise, key_fall;
`ifdef VOICE_STEAL_EN
  logic [VIW-1:0]          steal_ptr;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Down-counter per phase; each phase ends on terminal count zero.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt - CW'(1);
    case (state)
      S_IDLE: begin
        cnt_nx = cnt;
        if (sample_tick) begin
          state_nx = S_SCAN;
          cnt_nx   = CW'(NUM_KEYS - 1);
        end
      end
      S_SCAN: if (cnt == '0) begin
        state_nx = S_READ;
        cnt_nx   = CW'(NUM_VOICES - 1);
      end
      S_READ: if (cnt == '0) begin
        state_nx = S_WAIT;
        cnt_nx   = CW'(BRAM_LATENCY - 1);
      end
      S_WAIT: if (cnt == '0) begin
        state_nx = S_DONE;
        cnt_nx   = '0;
      end
      S_DONE: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active[v]) begin
        free_found = 1'b1;
        free_idx   = VIW'(v);
      end
    end
  end

  assign key_idx  = KIW'(CW'(NUM_KEYS - 1) - cnt);
  assign rv       = VIW'(CW'(NUM_VOICES - 1) - cnt);
  assign key_rise = snap[key_idx] & ~prev[key_idx];
  assign key_fall = ~snap[key_idx] & prev[key_idx];
  assign read_hit = (state == S_READ) && active[rv];
  assign acc_nx   = acc + (tag[BRAM_LATENCY-1] ?
                    {{(MIX_W-SAMPLE_WIDTH){bus.rd_data_in[SAMPLE_WIDTH-1]}}, bus.rd_data_in} :
                    MIX_W'(0));

  assign bus.rd_addr_out   = read_hit ? {note[rv], phase[rv]} : '0;
  assign bus.mix_out       = mix;
  assign bus.mix_valid_out = (state == S_DONE);
  assign voice_active_out  = active;
  assign busy_out          = (state != S_IDLE);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      snap   <= '0;
      prev   <= '0;
      active <= '0;
      tag    <= '0;
      acc    <= '0;
      mix    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        note[v]  <= '0;
        phase[v] <= '0;
      end
`ifdef VOICE_STEAL_EN
      steal_ptr <= '0;
`endif
    end else begin
      tag <= (tag << 1) | BRAM_LATENCY'(read_hit);
      acc <= acc_nx;
      case (state)
        S_IDLE: if (sample_tick) begin
          snap <= touch_status_in;
          acc  <= '0;
        end
        S_SCAN: begin
          prev[key_idx] <= snap[key_idx];
          if (key_rise) begin
            if (free_found) begin
              active[free_idx] <= 1'b1;
              note[free_idx]   <= NOTE_WIDTH'(key_idx);
              phase[free_idx]  <= '0;
            end
`ifdef VOICE_STEAL_EN
            else begin
              note[steal_ptr]  <= NOTE_WIDTH'(key_idx);
              phase[steal_ptr] <= '0;
              steal_ptr <= (steal_ptr == VIW'(NUM_VOICES - 1)) ? '0 : steal_ptr + VIW'(1);
            end
`endif
          end
          if (key_fall) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (active[v] && note[v] == NOTE_WIDTH'(key_idx)) active[v] <= 1'b0;
            end
          end
        end
        S_READ: if (read_hit) phase[rv] <= phase[rv] + ADDR_WIDTH'(1);
        S_WAIT: if (cnt == '0) mix <= acc_nx;
        default: ;
      endcase
    end
  end
endmodule
